// File: rtl/sigmoid_reg_loader_if.sv
// Stream-in / register-file-write bus of the sigmoid loader.
// master = loader side, slave = activation datapath plus register file side.
interface sigmoid_reg_loader_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              write_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output write_en,
        output address,
        output data_in
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  write_en,
        input  address,
        input  data_in
    );
endinterface

// File: rtl/sigmoid_reg_loader.sv
// Write-side sequencer for the sigmoid register file: streams activations to
// addresses 0..NUM_REGS-1, or zero-fills them on a clear command.
module sigmoid_reg_loader #(
    parameter int unsigned NUM_REGS = 18,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              clear,
    sigmoid_reg_loader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] data_q;
    logic              write_en_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            address_q  <= '0;
            data_q     <= '0;
            write_en_q <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Clear issues its address-0 write on entry so the zero-fill
                    // is back-to-back starting the cycle after the command.
                    if (clear) begin
                        write_en_q <= 1'b1;
                        address_q  <= '0;
                        data_q     <= '0;
                        count_q    <= ONE;
                        ptr_q      <= ONE;
                        if (LAST_ADDR == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CLEAR;
                            busy_q  <= 1'b1;
                        end
                    end else if (start) begin
                        state_q    <= LOAD;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        ptr_q      <= '0;
                        count_q    <= '0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        write_en_q <= 1'b1;
                        address_q  <= ptr_q;
                        data_q     <= bus.in_data;
                        count_q    <= count_q + ONE;
                        if (ptr_q == LAST_ADDR) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + ONE;
                        end
                    end
                end
                CLEAR: begin
                    write_en_q <= 1'b1;
                    address_q  <= ptr_q;
                    data_q     <= '0;
                    count_q    <= count_q + ONE;
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + ONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.write_en = write_en_q;
    assign bus.address  = address_q;
    assign bus.data_in  = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign count        = count_q;

endmodule

// File: tb/tb_sigmoid_reg_loader.sv
// Directed bench for sigmoid_reg_loader: reset, clear, load, stall, collisions, mid-pass reset.
module tb_sigmoid_reg_loader;

    localparam int unsigned NUM_REGS = 18;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned ADDR_W   = 5;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic              clear;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] count;

    int checks;
    int failures;
    int nwr;

    sigmoid_reg_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sigmoid_reg_loader #(
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .start(start),
        .clear(clear),
        .bus  (bus.master),
        .busy (busy),
        .done (done),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".write_en"}, 32'(bus.write_en), 32'd0);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, ".busy"},     32'(busy),         32'd0);
        chk({tag, ".done"},     32'(done),         32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_rst    = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset then idle
        for (int i = 0; i < 2; i++) begin
            step();
            chk_quiet("rst");
            chk("rst.count",   32'(count),       32'd0);
            chk("rst.address", 32'(bus.address), 32'd0);
            chk("rst.data_in", 32'(bus.data_in), 32'd0);
        end
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_quiet("idle");
            chk("idle.count", 32'(count), 32'd0);
        end

        // Clear pass: 18 back-to-back zero writes, done with address 17
        clear = 1'b1;
        for (int k = 0; k < 18; k++) begin
            step();
            clear = 1'b0;
            chk("clr.write_en", 32'(bus.write_en), 32'd1);
            chk("clr.address",  32'(bus.address),  32'(k));
            chk("clr.data_in",  32'(bus.data_in),  32'd0);
            chk("clr.in_ready", 32'(bus.in_ready), 32'd0);
            chk("clr.done",     32'(done),         (k == 17) ? 32'd1 : 32'd0);
            chk("clr.busy",     32'(busy),         (k == 17) ? 32'd0 : 32'd1);
        end
        step();
        chk_quiet("clr.after");
        chk("clr.count", 32'(count), 32'd18);

        // Back-to-back load with data k mod 16
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ld.in_ready0", 32'(bus.in_ready), 32'd1);
        chk("ld.busy0",     32'(busy),         32'd1);
        chk("ld.write_en0", 32'(bus.write_en), 32'd0);
        chk("ld.count0",    32'(count),        32'd0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            bus.in_data = 4'(k % 16);
            step();
            chk("ld.write_en", 32'(bus.write_en), 32'd1);
            chk("ld.address",  32'(bus.address),  32'(k));
            chk("ld.data_in",  32'(bus.data_in),  32'(k % 16));
            chk("ld.done",     32'(done),         (k == 17) ? 32'd1 : 32'd0);
            chk("ld.in_ready", 32'(bus.in_ready), (k == 17) ? 32'd0 : 32'd1);
            chk("ld.count",    32'(count),        32'(k + 1));
        end
        bus.in_data = 4'd7;
        step();
        chk_quiet("ld.19th");
        chk("ld.count_hold", 32'(count),       32'd18);
        chk("ld.addr_hold",  32'(bus.address), 32'd17);
        chk("ld.data_hold",  32'(bus.data_in), 32'd1);
        bus.in_valid = 1'b0;
        step();
        chk_quiet("ld.after");

        // Stalled load: alternating valid, data 15
        nwr = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 18; b++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'd15;
            step();
            if (bus.write_en === 1'b1) nwr++;
            chk("st.write_en", 32'(bus.write_en), 32'd1);
            chk("st.address",  32'(bus.address),  32'(b));
            chk("st.data_in",  32'(bus.data_in),  32'd15);
            chk("st.done",     32'(done),         (b == 17) ? 32'd1 : 32'd0);
            bus.in_valid = 1'b0;
            bus.in_data  = 4'd3;
            step();
            if (bus.write_en === 1'b1) nwr++;
            chk("st.gap_we",   32'(bus.write_en), 32'd0);
            chk("st.gap_addr", 32'(bus.address),  32'(b));
            chk("st.gap_data", 32'(bus.data_in),  32'd15);
            chk("st.gap_done", 32'(done),         32'd0);
        end
        chk("st.nwr",   32'(nwr),   32'd18);
        chk("st.count", 32'(count), 32'd18);

        // Start+clear collision -> clear; start mid-clear ignored
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        chk("col.write_en0", 32'(bus.write_en), 32'd1);
        chk("col.address0",  32'(bus.address),  32'd0);
        chk("col.in_ready0", 32'(bus.in_ready), 32'd0);
        for (int k = 1; k < 18; k++) begin
            if (k == 5) start = 1'b1;
            step();
            start = 1'b0;
            chk("col.write_en", 32'(bus.write_en), 32'd1);
            chk("col.address",  32'(bus.address),  32'(k));
            chk("col.data_in",  32'(bus.data_in),  32'd0);
            chk("col.in_ready", 32'(bus.in_ready), 32'd0);
        end
        chk("col.done", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet("col.idle");
        end

        // Reset mid-load after 7 beats
        start = 1'b1;
        step();
        start = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.in_data = 4'(k + 3);
            step();
            chk("mr.address", 32'(bus.address), 32'(k));
            chk("mr.data_in", 32'(bus.data_in), 32'(k + 3));
        end
        n_rst = 1'b0;
        #1;
        chk_quiet("mr.async");
        chk("mr.count", 32'(count), 32'd0);
        step();
        chk_quiet("mr.held");
        n_rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk_quiet("mr.release");
        start = 1'b1;
        step();
        start = 1'b0;
        chk("mr.in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd9;
        step();
        bus.in_valid = 1'b0;
        chk("mr.write_en", 32'(bus.write_en), 32'd1);
        chk("mr.address0", 32'(bus.address),  32'd0);
        chk("mr.data0",    32'(bus.data_in),  32'd9);
        chk("mr.count1",   32'(count),        32'd1);
        step();
        chk("mr.gap_we", 32'(bus.write_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/sigmoid_reg_loader.md
Name: sigmoid_reg_loader

Overview:
Write-side sequencer for the sigmoid register file. It accepts a stream of 4-bit sigmoid activations through a valid/ready handshake and drives the register file's write_en/address/data_in port. Stream element k is written to address k, for k = 0..NUM_REGS-1, where addresses 8..17 are the ten digit weights. It also provides a clear command that zero-fills every valid address. It sits between the sigmoid/activation datapath and the register file.

Parameters:
NUM_REGS, 18, number of valid register addresses (0..NUM_REGS-1); the last address written is NUM_REGS-1
DATA_W, 4, sigmoid value width
ADDR_W, 5, register file address width

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, begins a load pass (honoured in IDLE only)
clear  input  1  one-cycle pulse, begins a zero-fill pass (honoured in IDLE only)
in_valid  input  1  in_data is valid this cycle
in_data  input  DATA_W  sigmoid value
in_ready  output  1  loader accepts in_data this cycle
write_en  output  1  register file write enable
address  output  ADDR_W  register file address
data_in  output  DATA_W  register file write data
busy  output  1  high in LOAD or CLEAR
done  output  1  one-cycle pulse when a pass completes
count  output  ADDR_W  number of entries written in the current or last pass

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE.
  - in_ready, write_en, busy, done = 0.
  - address, data_in, count = 0.
  - Asserting reset mid-pass aborts the pass immediately. No further writes occur. done does not pulse.
- All outputs are registered. A write appears on write_en/address/data_in in the cycle after the handshake or clear step that caused it, and is held for exactly one cycle. write_en=0 in every other cycle.
- While write_en=0, address and data_in hold their last values.
- States: IDLE, LOAD, CLEAR, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - clear=1 -> CLEAR, with an internal pointer ptr=0.
  - Otherwise start=1 -> LOAD, with ptr=0.
  - clear has priority when start and clear are high in the same cycle.
  - count resets to 0 on entry to LOAD or CLEAR.
- LOAD:
  - in_ready=1, busy=1.
  - On each cycle with in_valid=1, the next cycle has write_en=1, address=ptr, data_in=in_data. ptr and count then increment.
  - A cycle with in_valid=0 produces no write and the pointer stalls. Gaps of any length are legal.
  - When the handshake at ptr=NUM_REGS-1 occurs:
    - in_ready drops to 0 in the following cycle.
    - The state goes to DONE.
    - The last write (address NUM_REGS-1) and done=1 appear in the same cycle.
- CLEAR:
  - busy=1, in_ready=0.
  - Issues NUM_REGS back-to-back writes of data_in=0 to addresses 0..NUM_REGS-1, one per cycle.
  - The first write appears the cycle after clear is sampled.
  - After the write to NUM_REGS-1 is issued, the state goes to DONE. done=1 coincides with the final write.
- DONE:
  - One cycle. done=1, busy=0, in_ready=0.
  - Then IDLE.
  - start and clear are ignored in DONE.
- start and clear pulses are ignored in LOAD and CLEAR. They do not queue.
- Address bound:
  - address never exceeds NUM_REGS-1 while write_en=1.
  - ptr does not wrap inside a pass.
  - No write is ever issued to an invalid address (NUM_REGS..31).
- Arithmetic:
  - ptr and count are ADDR_W bits wide.
  - count saturates at NUM_REGS (18) at the end of a pass and holds until the next pass starts.
- in_data is passed through unmodified. No range check is applied; all 4-bit values 0..15 are legal.

Test Plan:
- Reset then idle: n_rst=0 for 2 cycles, release, hold start/clear=0 for 5 cycles -> write_en=0, in_ready=0, busy=0, done=0, count=0 throughout.
- Clear pass: pulse clear -> 18 consecutive cycles with write_en=1, address 0..17, data_in=0. done=1 on the address-17 cycle. busy=0 and count=18 afterwards.
- Back-to-back load: pulse start, drive in_valid=1 with in_data=k mod 16 for k=0..17 -> writes (address k, data_in k mod 16); address 16 gets 0 and address 17 gets 1. done coincides with the address-17 write. in_ready=0 after the 18th handshake. A 19th in_valid produces no write.
- Stalled load: pulse start, in_valid alternating 1/0, in_data=15 -> exactly one write per accepted beat, addresses strictly increasing 0..17, data_in=15. 18 writes total; no write in gap cycles.
- Command collisions: start and clear together in IDLE -> CLEAR pass (data_in=0). A start pulse at ptr=5 of the clear pass is ignored (no LOAD follows; IDLE after done).
- Reset mid-load: after 7 accepted beats, assert n_rst=0 -> write_en, busy, in_ready=0 immediately. No done pulse. After release, a new start begins again at address 0.
